// File: rtl/pipeline_stall_controller.sv
// ----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Stall/flush controller for a five-stage pipeline. The pipeline register
// controls are decoded combinationally from the current state and the
// request inputs, so they act in the same cycle. The state, the memory wait
// counter, the sticky timeout flag and three saturating performance counters
// are registered.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | normal flow: memory wait > branch flush > hazard stall
// MEM_WAIT  | load/store outstanding, whole pipe frozen until ready
// TIMEOUT   | memory never answered: frozen, error flag held until reset
// ILLEGAL   | unused encoding: controls low, return to RUN
//
// Ports
//   clk                    : clock, all state changes on the rising edge
//   reset                  : synchronous reset, active low
//   i_Sig_Hazard_Detected  : ID-stage data hazard request
//   i_Sig_Branch_Taken     : EXE-stage branch resolved taken
//   i_Sig_Memory_Access    : MEM-stage load/store in flight
//   i_Sig_Memory_Ready     : data memory completes the access this cycle
//   i_Sig_Counter_Clear    : synchronous clear of the performance counters
//   o_Sig_Freeze_PC        : hold the PC
//   o_Sig_Freeze_IF_ID     : hold the IF/ID register
//   o_Sig_Freeze_Pipeline  : hold the ID/EXE, EXE/MEM, MEM/WB registers
//   o_Sig_Flush_IF_ID      : clear the IF/ID register
//   o_Sig_Flush_ID_EXE     : clear the ID/EXE register (bubble)
//   o_Sig_Memory_Timeout   : sticky memory timeout error
//   o_State                : current FSM state
//   o_Hazard_Stall_Count   : cycles spent in a hazard bubble
//   o_Memory_Stall_Count   : cycles frozen waiting on memory
//   o_Flush_Count          : cycles flushing for a taken branch
// ----------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int COUNT_WIDTH = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_Sig_Hazard_Detected,
    input  logic                   i_Sig_Branch_Taken,
    input  logic                   i_Sig_Memory_Access,
    input  logic                   i_Sig_Memory_Ready,
    input  logic                   i_Sig_Counter_Clear,
    output logic                   o_Sig_Freeze_PC,
    output logic                   o_Sig_Freeze_IF_ID,
    output logic                   o_Sig_Freeze_Pipeline,
    output logic                   o_Sig_Flush_IF_ID,
    output logic                   o_Sig_Flush_ID_EXE,
    output logic                   o_Sig_Memory_Timeout,
    output logic [1:0]             o_State,
    output logic [COUNT_WIDTH-1:0] o_Hazard_Stall_Count,
    output logic [COUNT_WIDTH-1:0] o_Memory_Stall_Count,
    output logic [COUNT_WIDTH-1:0] o_Flush_Count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]      WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_TIMEOUT  = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    state_t                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                   timeout_q, timeout_d;
    logic [COUNT_WIDTH-1:0] haz_cnt_q, haz_cnt_d;
    logic [COUNT_WIDTH-1:0] mem_cnt_q, mem_cnt_d;
    logic [COUNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze_pc, freeze_if_id, freeze_pipe, flush_if_id, flush_id_exe;
    logic inc_haz, inc_mem, inc_flush;
    logic resolve_bh;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        freeze_pipe  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        inc_haz      = 1'b0;
        inc_mem      = 1'b0;
        inc_flush    = 1'b0;
        resolve_bh   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (i_Sig_Memory_Access && !i_Sig_Memory_Ready) begin
                    freeze_pc    = 1'b1;
                    freeze_if_id = 1'b1;
                    freeze_pipe  = 1'b1;
                    inc_mem      = 1'b1;
                    state_d      = ST_MEM_WAIT;
                    wait_cnt_d   = WAIT_W'(1);
                end else begin
                    resolve_bh = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // Ready wins over a same-cycle timeout.
                if (i_Sig_Memory_Ready) begin
                    resolve_bh = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    freeze_pc    = 1'b1;
                    freeze_if_id = 1'b1;
                    freeze_pipe  = 1'b1;
                    inc_mem      = 1'b1;
                    if (wait_cnt_q == WAIT_LIMIT) begin
                        state_d   = ST_TIMEOUT;
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            ST_TIMEOUT: begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                freeze_pipe  = 1'b1;
                timeout_d    = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        // A taken branch makes the hazarding ID instruction wrong-path,
        // so the bubble is only inserted when no branch is flushing.
        if (resolve_bh) begin
            if (i_Sig_Branch_Taken) begin
                flush_if_id  = 1'b1;
                flush_id_exe = 1'b1;
                inc_flush    = 1'b1;
            end else if (i_Sig_Hazard_Detected) begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                flush_id_exe = 1'b1;
                inc_haz      = 1'b1;
            end
        end

        haz_cnt_d   = haz_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (i_Sig_Counter_Clear) begin
            haz_cnt_d   = '0;
            mem_cnt_d   = '0;
            flush_cnt_d = '0;
        end else begin
            if (inc_haz && haz_cnt_q != CNT_MAX) begin
                haz_cnt_d = haz_cnt_q + COUNT_WIDTH'(1);
            end
            if (inc_mem && mem_cnt_q != CNT_MAX) begin
                mem_cnt_d = mem_cnt_q + COUNT_WIDTH'(1);
            end
            if (inc_flush && flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            haz_cnt_q   <= '0;
            mem_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            haz_cnt_q   <= haz_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Controls are forced low for as long as reset is held.
    assign o_Sig_Freeze_PC       = reset & freeze_pc;
    assign o_Sig_Freeze_IF_ID    = reset & freeze_if_id;
    assign o_Sig_Freeze_Pipeline = reset & freeze_pipe;
    assign o_Sig_Flush_IF_ID     = reset & flush_if_id;
    assign o_Sig_Flush_ID_EXE    = reset & flush_id_exe;

    assign o_Sig_Memory_Timeout  = timeout_q;
    assign o_State               = state_q;
    assign o_Hazard_Stall_Count  = haz_cnt_q;
    assign o_Memory_Stall_Count  = mem_cnt_q;
    assign o_Flush_Count         = flush_cnt_q;

endmodule
